miriscv_decode_stage: RTL and testbench
=======================================

# miriscv_decode_stage

Registered, parametrised RV32I/RV32M decode stage between fetch and execute of the miriscv core. Accepts one instruction per cycle from fetch over a valid/ready handshake, decodes opcode class, ALU/MDU operation, operand selects, memory controls, register indices and the sign-extended immediate, and presents them to execute after a pipeline register. A two-entry skid buffer keeps full throughput with registered back-pressure. The stage also supports flush and keeps a saturating illegal-instruction counter.

## Interface
- XLEN, 32: datapath width of `pc_*` and `imm_o`; 32 or 64.
- M_EXT, 0: 1 decodes the RV32M MUL/DIV/REM group; 0 treats it as illegal.
- SKID, 1: 1 selects the 2-entry skid buffer with registered `instr_ready_o`; 0 selects a single register.
- CNT_W, 16: width of `illegal_cnt_o`.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discards all buffered instructions.
- instr_i  in  32  fetched instruction.
- pc_i  in  XLEN  PC of `instr_i`.
- instr_valid_i / instr_ready_o  in/out  1  fetch handshake.
- dec_valid_o / dec_ready_i  out/in  1  execute handshake.
- pc_o  out  XLEN  PC of presented instruction.
- rs1_o, rs2_o, rd_o  out  5 each  raw fields [19:15], [24:20], [11:7].
- imm_o  out  XLEN  sign-extended immediate.
- ex_op_a_sel_o  out  2; ex_op_b_sel_o  out  3; alu_op_o  out  6  (miriscv_defines encodings).
- md_en_o  out  1; md_op_o  out  3  MDU request and funct3.
- mem_req_o, mem_we_o  out  1 each; mem_size_o  out  3.
- gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o, jalr_o  out  1 each.
- illegal_cnt_o  out  CNT_W  saturating count of illegal instructions handed to execute.

## Operation
- Decode is combinational on the accepted `instr_i` and captured together with `pc_i` into the buffer entry.
- Opcode classes: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM. `instr_i[1:0]` ≠ 2'b11 or any other opcode is illegal.
- Selects and ALU ops per class follow the miriscv_defines encodings.
  - OP: a=0, b=0.
  - OP_IMM and LOAD: a=0, b=1.
  - STORE: a=0, b=3.
  - BRANCH: a=0, b=0, comparison ops EQ/NE/LTS/GES/LTU/GEU.
  - JAL and JALR: a=1, b=4, ADD.
  - LUI: a=2, b=2, ADD.
  - AUIPC: a=1, b=2, ADD.
- Illegal encodings:
  - funct7/funct3 combinations outside RV32I.
  - LOAD funct3 011, 110 or 111.
  - STORE funct3 greater than 010.
  - BRANCH funct3 010 or 011.
  - Shift-immediate with a bad funct7.
- M_EXT=1 with OP and funct7=0000001: `md_en_o`=1, `md_op_o`=funct3, `gpr_we_a_o`=1, `alu_op_o`=ALU_ADD, a=0, b=0. The same encoding with M_EXT=0 is illegal.
- Immediates, sign-extended from bit 31 to XLEN:
  - I (OP_IMM, LOAD, JALR): [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All other classes: 0.
- Illegal instruction: `illegal_instr_o`=1 and `mem_req_o`, `mem_we_o`, `gpr_we_a_o`, `branch_o`, `jal_o`, `jalr_o`, `md_en_o` are all forced to 0.
- MISC_MEM and SYSTEM are legal with no side-effect outputs.
- `illegal_cnt_o` increments when `dec_valid_o & dec_ready_i & illegal_instr_o` and saturates at all-ones.

## Timing
- Reset: buffer empty, `dec_valid_o`=0, `instr_ready_o`=1 on the cycle after reset. All decoded outputs are 0 and `illegal_cnt_o`=0.
- Latency: an instruction accepted at edge N is presented with `dec_valid_o`=1 after edge N, i.e. 1 cycle.
- Outputs hold stable while `dec_valid_o & !dec_ready_i`.
- Order is strictly preserved.
- SKID=1:
  - `instr_ready_o` is a flop, equal to "skid entry empty".
  - An accept while the output is stalled fills the skid entry, and ready drops on the next cycle.
  - When the output transfers, the skid entry moves to the output.
  - Sustained throughput is 1 per cycle.
- SKID=0: `instr_ready_o` = `!dec_valid_o | dec_ready_i` (combinational).
- Simultaneous transfer-out and accept: the new instruction replaces the output entry with no bubble.
- `flush_i`: both entries are invalidated at the edge, and the input beat offered in that cycle is dropped. `dec_valid_o`=0 on the next cycle and `instr_ready_o`=1 on the next cycle. The counter is unaffected except by a transfer in the flush cycle itself.
- Reset has priority over flush. Reset mid-stall discards all entries.

## Test plan
- Hand over `0x00500093` (addi x1,x0,5) with `dec_ready_i`=1:
  - next cycle `dec_valid_o`=1, `alu_op_o`=ALU_ADD, a=0, b=1, `imm_o`=5, `rd_o`=1, `gpr_we_a_o`=1.
- `0xFE208EE3` (beq x1,x2,-4):
  - `branch_o`=1, `alu_op_o`=ALU_EQ, `imm_o`=0xFFFFFFFC, `rs1_o`=1, `rs2_o`=2, `gpr_we_a_o`=0.
- `0x022081B3` (mul x3,x1,x2):
  - M_EXT=1: `md_en_o`=1, `md_op_o`=000, `rd_o`=3.
  - M_EXT=0: `illegal_instr_o`=1, `gpr_we_a_o`=0.
- SKID=1, `dec_ready_i`=0, offer three back-to-back instructions:
  - first two are accepted and `instr_ready_o`=0 from the cycle after the second accept.
  - raising `dec_ready_i` drains them in order with no loss.
- CNT_W=2, transfer five `0x00000000` words:
  - each has `illegal_instr_o`=1 and `mem_req_o`=0.
  - `illegal_cnt_o` reads 1, 2, 3, 3, 3.
- Fill both entries, assert `flush_i` together with a new valid beat:
  - next cycle `dec_valid_o`=0 and `instr_ready_o`=1.
  - the flushed and the concurrent beats never appear at the output.

Source files
------------

// File: rtl/miriscv_decode_stage.sv
// miriscv decode stage: RV32I/RV32M decoder feeding execute through a registered
// output entry, optionally backed by a skid entry so instr_ready_o is a flop.
module miriscv_decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 0,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [1:0]       ex_op_a_sel_o,
    output logic [2:0]       ex_op_b_sel_o,
    output logic [5:0]       alu_op_o,
    output logic             md_en_o,
    output logic [2:0]       md_op_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [2:0]       mem_size_o,
    output logic             gpr_we_a_o,
    output logic             wb_src_sel_o,
    output logic             illegal_instr_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);
    localparam logic [5:0] ALU_ADD  = 6'b011000, ALU_SUB  = 6'b011001, ALU_XOR = 6'b101111;
    localparam logic [5:0] ALU_OR   = 6'b101110, ALU_AND  = 6'b010101, ALU_SRA = 6'b100100;
    localparam logic [5:0] ALU_SRL  = 6'b100101, ALU_SLL  = 6'b100111, ALU_LTS = 6'b000000;
    localparam logic [5:0] ALU_LTU  = 6'b000001, ALU_GES  = 6'b001010, ALU_GEU = 6'b001011;
    localparam logic [5:0] ALU_EQ   = 6'b001100, ALU_NE   = 6'b001101, ALU_SLTS = 6'b000010;
    localparam logic [5:0] ALU_SLTU = 6'b000011;

    localparam logic [6:0] OPC_OP    = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111, OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111, OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [1:0]      a_sel;
        logic [2:0]      b_sel;
        logic [5:0]      alu_op;
        logic            md_en;
        logic [2:0]      md_op;
        logic            mem_req;
        logic            mem_we;
        logic [2:0]      mem_size;
        logic            gpr_we;
        logic            wb_src;
        logic            illegal;
        logic            branch;
        logic            jal;
        logic            jalr;
    } entry_t;

    function automatic logic [5:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLTS;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    entry_t           dec_d, out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      imm32;
    logic             illegal, alt;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             out_fire, accept;

    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign alt    = (funct7 == 7'b0100000);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_d     = '0;
        dec_d.pc  = pc_i;
        dec_d.rs1 = instr_i[19:15];
        dec_d.rs2 = instr_i[24:20];
        dec_d.rd  = instr_i[11:7];
        imm32     = '0;
        illegal   = (instr_i[1:0] != 2'b11);
        case (instr_i[6:0])
            OPC_OP: begin
                dec_d.gpr_we = 1'b1;
                if (funct7 == 7'b0000001) begin
                    dec_d.alu_op = ALU_ADD;
                    dec_d.md_en  = (M_EXT != 0);
                    dec_d.md_op  = funct3;
                    if (M_EXT == 0) illegal = 1'b1;
                end else begin
                    dec_d.alu_op = arith_op(funct3, alt);
                    if (funct7 != 7'b0 && !(alt && (funct3 == 3'b000 || funct3 == 3'b101)))
                        illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_d.b_sel  = 3'd1;
                dec_d.gpr_we = 1'b1;
                dec_d.alu_op = arith_op(funct3, alt && (funct3 == 3'b101));
                imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
                if ((funct3 == 3'b001 && funct7 != 7'b0) ||
                    (funct3 == 3'b101 && funct7 != 7'b0 && !alt))
                    illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_d.b_sel    = 3'd1;
                dec_d.alu_op   = ALU_ADD;
                dec_d.mem_req  = 1'b1;
                dec_d.mem_size = funct3;
                dec_d.gpr_we   = 1'b1;
                dec_d.wb_src   = 1'b1;
                imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_d.b_sel    = 3'd3;
                dec_d.alu_op   = ALU_ADD;
                dec_d.mem_req  = 1'b1;
                dec_d.mem_we   = 1'b1;
                dec_d.mem_size = funct3;
                imm32          = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                if (funct3 > 3'b010) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_d.branch = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
                case (funct3)
                    3'b000:  dec_d.alu_op = ALU_EQ;
                    3'b001:  dec_d.alu_op = ALU_NE;
                    3'b100:  dec_d.alu_op = ALU_LTS;
                    3'b101:  dec_d.alu_op = ALU_GES;
                    3'b110:  dec_d.alu_op = ALU_LTU;
                    3'b111:  dec_d.alu_op = ALU_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_d.a_sel  = 2'd1;
                dec_d.b_sel  = 3'd4;
                dec_d.alu_op = ALU_ADD;
                dec_d.gpr_we = 1'b1;
                if (instr_i[3]) begin
                    dec_d.jal = 1'b1;
                    imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
                end else begin
                    dec_d.jalr = 1'b1;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                    if (funct3 != 3'b000) illegal = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_d.a_sel  = instr_i[5] ? 2'd2 : 2'd1;
                dec_d.b_sel  = 3'd2;
                dec_d.alu_op = ALU_ADD;
                dec_d.gpr_we = 1'b1;
                imm32        = {instr_i[31:12], 12'b0};
            end
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
        dec_d.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        if (illegal) begin
            dec_d.mem_req = 1'b0;
            dec_d.mem_we  = 1'b0;
            dec_d.gpr_we  = 1'b0;
            dec_d.branch  = 1'b0;
            dec_d.jal     = 1'b0;
            dec_d.jalr    = 1'b0;
            dec_d.md_en   = 1'b0;
        end
        dec_d.illegal = illegal;
    end

    assign instr_ready_o = (SKID != 0) ? !skid_valid_q : (!out_valid_q || dec_ready_i);
    assign out_fire      = out_valid_q && dec_ready_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = dec_d;
            end
        end else if (accept) begin
            skid_d       = dec_d;
            skid_valid_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (out_fire && out_q.illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // NOTE: skid payload is only read while skid_valid_q is set, so it carries no reset.
    always_ff @(posedge clk_i) skid_q <= skid_d;

    assign dec_valid_o     = out_valid_q;
    assign pc_o            = out_q.pc;
    assign rs1_o           = out_q.rs1;
    assign rs2_o           = out_q.rs2;
    assign rd_o            = out_q.rd;
    assign imm_o           = out_q.imm;
    assign ex_op_a_sel_o   = out_q.a_sel;
    assign ex_op_b_sel_o   = out_q.b_sel;
    assign alu_op_o        = out_q.alu_op;
    assign md_en_o         = out_q.md_en;
    assign md_op_o         = out_q.md_op;
    assign mem_req_o       = out_q.mem_req;
    assign mem_we_o        = out_q.mem_we;
    assign mem_size_o      = out_q.mem_size;
    assign gpr_we_a_o      = out_q.gpr_we;
    assign wb_src_sel_o    = out_q.wb_src;
    assign illegal_instr_o = out_q.illegal;
    assign branch_o        = out_q.branch;
    assign jal_o           = out_q.jal;
    assign jalr_o          = out_q.jalr;
    assign illegal_cnt_o   = cnt_q;
endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Directed bench: dut_a is M_EXT=1/SKID=1/CNT_W=2, dut_b is M_EXT=0/SKID=0/CNT_W=16,
// both fed the same fetch beats; expectations are hand-derived instruction encodings.
module tb_miriscv_decode_stage;
    localparam logic [5:0] ALU_ADD = 6'b011000, ALU_EQ = 6'b001100, ALU_SRA = 6'b100100;
    localparam logic [31:0] I1 = 32'h00100093, I2 = 32'h00200113, I3 = 32'h00300193, I4 = 32'h00400213;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, vld, rdy_a, rdy_b;
    logic [31:0] instr, pc;

    logic        ready_a, valid_a, md_en_a, mreq_a, mwe_a, we_a, wbs_a, ill_a, br_a, jal_a, jalr_a;
    logic [31:0] pc_a, imm_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [1:0]  asel_a, cnt_a;
    logic [2:0]  bsel_a, md_op_a, msize_a;
    logic [5:0]  alu_a;

    logic        ready_b, valid_b, md_en_b, mreq_b, mwe_b, we_b, wbs_b, ill_b, br_b, jal_b, jalr_b;
    logic [31:0] pc_b, imm_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [1:0]  asel_b;
    logic [2:0]  bsel_b, md_op_b, msize_b;
    logic [5:0]  alu_b;
    logic [15:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    miriscv_decode_stage #(.XLEN(32), .M_EXT(1), .SKID(1), .CNT_W(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(vld), .instr_ready_o(ready_a), .dec_valid_o(valid_a), .dec_ready_i(rdy_a),
        .pc_o(pc_a), .rs1_o(rs1_a), .rs2_o(rs2_a), .rd_o(rd_a), .imm_o(imm_a),
        .ex_op_a_sel_o(asel_a), .ex_op_b_sel_o(bsel_a), .alu_op_o(alu_a),
        .md_en_o(md_en_a), .md_op_o(md_op_a), .mem_req_o(mreq_a), .mem_we_o(mwe_a),
        .mem_size_o(msize_a), .gpr_we_a_o(we_a), .wb_src_sel_o(wbs_a), .illegal_instr_o(ill_a),
        .branch_o(br_a), .jal_o(jal_a), .jalr_o(jalr_a), .illegal_cnt_o(cnt_a)
    );

    miriscv_decode_stage #(.XLEN(32), .M_EXT(0), .SKID(0), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc),
        .instr_valid_i(vld), .instr_ready_o(ready_b), .dec_valid_o(valid_b), .dec_ready_i(rdy_b),
        .pc_o(pc_b), .rs1_o(rs1_b), .rs2_o(rs2_b), .rd_o(rd_b), .imm_o(imm_b),
        .ex_op_a_sel_o(asel_b), .ex_op_b_sel_o(bsel_b), .alu_op_o(alu_b),
        .md_en_o(md_en_b), .md_op_o(md_op_b), .mem_req_o(mreq_b), .mem_we_o(mwe_b),
        .mem_size_o(msize_b), .gpr_we_a_o(we_b), .wb_src_sel_o(wbs_b), .illegal_instr_o(ill_b),
        .branch_o(br_b), .jal_o(jal_b), .jalr_o(jalr_b), .illegal_cnt_o(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; vld = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; instr = '0; pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] i_word, input logic [31:0] i_pc);
        instr = i_word; pc = i_pc; vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %0h expected 0", valid_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %0h expected 1", ready_a); end
        n_checks++; if (imm_a !== 32'h0) begin n_fail++; $display("FAIL reset_imm_a: got %h expected 0", imm_a); end
        n_checks++; if (alu_a !== 6'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL reset_we_a: got %0h expected 0", we_a); end
        n_checks++; if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d expected 0", cnt_a); end
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %0h expected 0", valid_b); end
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %0h expected 1", ready_b); end
    endtask

    task automatic test_addi();
        issue(32'h00500093, 32'h100);
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h expected 1", valid_a); end
        n_checks++; if (alu_a !== ALU_ADD) begin n_fail++; $display("FAIL addi_alu: got %h expected %h", alu_a, ALU_ADD); end
        n_checks++; if ({asel_a, bsel_a} !== {2'd0, 3'd1}) begin n_fail++; $display("FAIL addi_sel: got a=%0d b=%0d expected a=0 b=1", asel_a, bsel_a); end
        n_checks++; if (imm_a !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h expected 5", imm_a); end
        n_checks++; if (rd_a !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d expected 1", rd_a); end
        n_checks++; if (we_a !== 1'b1) begin n_fail++; $display("FAIL addi_we: got %0h expected 1", we_a); end
        n_checks++; if (pc_a !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h expected 100", pc_a); end
        n_checks++; if ({valid_b, imm_b} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL addi_b: got v=%0h imm=%h expected v=1 imm=5", valid_b, imm_b); end
    endtask

    task automatic test_back_to_back();
        issue(32'hFE208EE3, 32'h104);
        n_checks++; if ({valid_a, br_a} !== 2'b11) begin n_fail++; $display("FAIL beq_branch: got v=%0h br=%0h expected 1 1", valid_a, br_a); end
        n_checks++; if (alu_a !== ALU_EQ) begin n_fail++; $display("FAIL beq_alu: got %h expected %h", alu_a, ALU_EQ); end
        n_checks++; if (imm_a !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %h expected fffffffc", imm_a); end
        n_checks++; if ({rs1_a, rs2_a} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL beq_rs: got %0d %0d expected 1 2", rs1_a, rs2_a); end
        n_checks++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL beq_we: got %0h expected 0", we_a); end
        issue(32'h022081B3, 32'h108);
        n_checks++; if ({md_en_a, md_op_a} !== {1'b1, 3'b000}) begin n_fail++; $display("FAIL mul_md_a: got en=%0h op=%0h expected 1 0", md_en_a, md_op_a); end
        n_checks++; if ({rd_a, we_a, ill_a} !== {5'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mul_rd_a: got rd=%0d we=%0h ill=%0h expected 3 1 0", rd_a, we_a, ill_a); end
        n_checks++; if ({ill_b, we_b, md_en_b} !== 3'b100) begin n_fail++; $display("FAIL mul_illegal_b: got ill=%0h we=%0h md=%0h expected 1 0 0", ill_b, we_b, md_en_b); end
        tick();
        n_checks++; if (cnt_b !== 16'd1) begin n_fail++; $display("FAIL mul_cnt_b: got %0d expected 1", cnt_b); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL drain_valid_a: got %0h expected 0", valid_a); end
    endtask

    task automatic test_classes();
        issue(32'h00812283, 32'h110);
        n_checks++; if ({mreq_a, mwe_a, wbs_a, msize_a, bsel_a} !== {3'b101, 3'd2, 3'd1}) begin n_fail++; $display("FAIL lw_ctrl: got req=%0h we=%0h wb=%0h sz=%0d b=%0d expected 1 0 1 2 1", mreq_a, mwe_a, wbs_a, msize_a, bsel_a); end
        n_checks++; if (imm_a !== 32'd8) begin n_fail++; $display("FAIL lw_imm: got %h expected 8", imm_a); end
        issue(32'h00512623, 32'h114);
        n_checks++; if ({mreq_a, mwe_a, we_a, bsel_a} !== {3'b110, 3'd3}) begin n_fail++; $display("FAIL sw_ctrl: got req=%0h we=%0h gwe=%0h b=%0d expected 1 1 0 3", mreq_a, mwe_a, we_a, bsel_a); end
        n_checks++; if (imm_a !== 32'hC) begin n_fail++; $display("FAIL sw_imm: got %h expected c", imm_a); end
        issue(32'h123453B7, 32'h118);
        n_checks++; if ({imm_a, asel_a, bsel_a, we_a} !== {32'h12345000, 2'd2, 3'd2, 1'b1}) begin n_fail++; $display("FAIL lui: got imm=%h a=%0d b=%0d we=%0h expected 12345000 2 2 1", imm_a, asel_a, bsel_a, we_a); end
        issue(32'h010000EF, 32'h11C);
        n_checks++; if ({jal_a, asel_a, bsel_a, imm_a} !== {1'b1, 2'd1, 3'd4, 32'h10}) begin n_fail++; $display("FAIL jal: got jal=%0h a=%0d b=%0d imm=%h expected 1 1 4 10", jal_a, asel_a, bsel_a, imm_a); end
        issue(32'h4010D093, 32'h120);
        n_checks++; if ({alu_a, ill_a} !== {ALU_SRA, 1'b0}) begin n_fail++; $display("FAIL srai: got alu=%h ill=%0h expected %h 0", alu_a, ill_a, ALU_SRA); end
        issue(32'h40109093, 32'h124);
        n_checks++; if ({ill_a, we_a} !== 2'b10) begin n_fail++; $display("FAIL slli_badf7: got ill=%0h we=%0h expected 1 0", ill_a, we_a); end
        issue(32'h00813283, 32'h128);
        n_checks++; if ({ill_a, mreq_a} !== 2'b10) begin n_fail++; $display("FAIL load_f3_011: got ill=%0h req=%0h expected 1 0", ill_a, mreq_a); end
        tick();
    endtask

    task automatic test_skid();
        rdy_a = 1'b0; rdy_b = 1'b0;
        instr = I1; pc = 32'h200; vld = 1'b1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL skid_ready0: got %0h expected 1", ready_a); end
        tick();
        n_checks++; if ({valid_a, rd_a, ready_a} !== {1'b1, 5'd1, 1'b1}) begin n_fail++; $display("FAIL skid_first: got v=%0h rd=%0d rdy=%0h expected 1 1 1", valid_a, rd_a, ready_a); end
        n_checks++; if (ready_b !== 1'b0) begin n_fail++; $display("FAIL skid0_ready_stall: got %0h expected 0", ready_b); end
        instr = I2; pc = 32'h204;
        tick();
        n_checks++; if ({ready_a, rd_a, pc_a} !== {1'b0, 5'd1, 32'h200}) begin n_fail++; $display("FAIL skid_full: got rdy=%0h rd=%0d pc=%h expected 0 1 200", ready_a, rd_a, pc_a); end
        instr = I3; pc = 32'h208;
        tick();
        n_checks++; if ({ready_a, rd_a} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL skid_hold: got rdy=%0h rd=%0d expected 0 1", ready_a, rd_a); end
        rdy_a = 1'b1; rdy_b = 1'b1;
        #1;
        n_checks++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL skid0_ready_comb: got %0h expected 1", ready_b); end
        tick();
        n_checks++; if ({valid_a, rd_a, pc_a, ready_a} !== {1'b1, 5'd2, 32'h204, 1'b1}) begin n_fail++; $display("FAIL skid_drain2: got v=%0h rd=%0d pc=%h rdy=%0h expected 1 2 204 1", valid_a, rd_a, pc_a, ready_a); end
        tick();
        n_checks++; if ({valid_a, rd_a, pc_a} !== {1'b1, 5'd3, 32'h208}) begin n_fail++; $display("FAIL skid_drain3: got v=%0h rd=%0d pc=%h expected 1 3 208", valid_a, rd_a, pc_a); end
        vld = 1'b0;
        tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL skid_empty: got %0h expected 0", valid_a); end
    endtask

    task automatic test_counter();
        rdy_a = 1'b0;
        issue(I1, 32'h280);
        issue(I2, 32'h284);
        do_reset();
        n_checks++; if ({valid_a, ready_a} !== 2'b01) begin n_fail++; $display("FAIL reset_mid_stall: got v=%0h rdy=%0h expected 0 1", valid_a, ready_a); end
        instr = 32'h0; pc = 32'h300; vld = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            int exp_c;
            tick();
            if (k == 5) vld = 1'b0;
            exp_c = (k - 1 > 3) ? 3 : k - 1;
            n_checks++; if ({valid_a, ill_a, mreq_a} !== 3'b110) begin n_fail++; $display("FAIL cnt_beat%0d: got v=%0h ill=%0h req=%0h expected 1 1 0", k, valid_a, ill_a, mreq_a); end
            n_checks++; if (cnt_a !== 2'(exp_c)) begin n_fail++; $display("FAIL cnt_value%0d: got %0d expected %0d", k, cnt_a, exp_c); end
        end
        tick();
        n_checks++; if ({valid_a, cnt_a} !== {1'b0, 2'd3}) begin n_fail++; $display("FAIL cnt_sat: got v=%0h cnt=%0d expected 0 3", valid_a, cnt_a); end
        n_checks++; if (cnt_b !== 16'd5) begin n_fail++; $display("FAIL cnt_b: got %0d expected 5", cnt_b); end
    endtask

    task automatic test_flush();
        rdy_a = 1'b0; rdy_b = 1'b1;
        issue(I1, 32'h400);
        issue(I2, 32'h404);
        n_checks++; if ({ready_a, valid_b} !== 2'b01) begin n_fail++; $display("FAIL flush_fill: got rdy_a=%0h v_b=%0h expected 0 1", ready_a, valid_b); end
        flush = 1'b1; instr = I3; pc = 32'h408; vld = 1'b1;
        tick();
        flush = 1'b0; vld = 1'b0;
        n_checks++; if ({valid_a, ready_a} !== 2'b01) begin n_fail++; $display("FAIL flush_a: got v=%0h rdy=%0h expected 0 1", valid_a, ready_a); end
        n_checks++; if ({valid_b, ready_b} !== 2'b01) begin n_fail++; $display("FAIL flush_b: got v=%0h rdy=%0h expected 0 1", valid_b, ready_b); end
        rdy_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if ({valid_a, valid_b} !== 2'b00) begin n_fail++; $display("FAIL flush_leak%0d: got v_a=%0h v_b=%0h expected 0 0", k, valid_a, valid_b); end
        end
        issue(I4, 32'h40C);
        n_checks++; if ({valid_a, rd_a, pc_a} !== {1'b1, 5'd4, 32'h40C}) begin n_fail++; $display("FAIL post_flush: got v=%0h rd=%0d pc=%h expected 1 4 40c", valid_a, rd_a, pc_a); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_classes();
        test_skid();
        test_counter();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
